// File: rtl/df_seq.sv
// Data-fetch sequencer: walks the weight and input memories in lockstep and strobes each pair to the fetch register.
// Optional build macro DF_SEQ_ZERO_SKIP_EN suppresses pairs whose input word reads as zero.
module df_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] w_base,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  hold,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] w_rdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] data_w_new,
    output logic [DATA_WIDTH-1:0] data_i_new,
    output logic                  sel_rdy,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beat_cnt,
    output logic [1:0]            dbg_state
);

    // Handshake: sel_rdy is a one-cycle strobe with no back-pressure; hold only gates new reads,
    // every read already issued is delivered two cycles later.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  mem_re_q, mem_re_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ADDR_WIDTH-1:0] i_addr_q, i_addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  pend_q, pend_d;
    logic                  sel_rdy_q, sel_rdy_d;
    logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
    logic [DATA_WIDTH-1:0] data_i_q, data_i_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  rem_left;
    logic                  keep_pair;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mem_re_q  <= 1'b0;
            w_addr_q  <= '0;
            i_addr_q  <= '0;
            rem_q     <= '0;
            pend_q    <= 1'b0;
            sel_rdy_q <= 1'b0;
            data_w_q  <= '0;
            data_i_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            mem_re_q  <= mem_re_d;
            w_addr_q  <= w_addr_d;
            i_addr_q  <= i_addr_d;
            rem_q     <= rem_d;
            pend_q    <= pend_d;
            sel_rdy_q <= sel_rdy_d;
            data_w_q  <= data_w_d;
            data_i_q  <= data_i_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            beat_q    <= beat_d;
        end
    end

    // rem_q counts reads not yet issued, including the one presented this cycle on mem_re.
    always_comb begin
        state_d  = state_q;
        mem_re_d = 1'b0;
        w_addr_d = w_addr_q;
        i_addr_d = i_addr_q;
        rem_d    = rem_q;
        rem_left = rem_q - LEN_WIDTH'(mem_re_q);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_addr_d = w_base;
                    i_addr_d = i_base;
                    rem_d    = len;
                    if (len != '0) begin
                        state_d  = ST_FETCH;
                        mem_re_d = ~hold;
                    end else begin
                        // Empty request still spends one busy cycle before done.
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_FETCH: begin
                rem_d = rem_left;
                if (mem_re_q) begin
                    w_addr_d = w_addr_q + ADDR_WIDTH'(1);
                    i_addr_d = i_addr_q + ADDR_WIDTH'(1);
                end
                if (rem_left == '0) state_d = ST_DRAIN;
                else                mem_re_d = ~hold;
            end
            ST_DRAIN: begin
                if (!pend_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Read pipeline: mem_re at T, rdata captured at the end of T+1, strobe at T+2.
    always_comb begin
        pend_d = mem_re_q;
`ifdef DF_SEQ_ZERO_SKIP_EN
        keep_pair = pend_q && (i_rdata != '0);
`else
        keep_pair = pend_q;
`endif
        sel_rdy_d = keep_pair;
        data_w_d  = keep_pair ? w_rdata : '0;
        data_i_d  = keep_pair ? i_rdata : '0;
        beat_d    = beat_q;
        if (state_q == ST_IDLE && start) beat_d = '0;
        else if (keep_pair)              beat_d = beat_q + LEN_WIDTH'(1);
    end

    assign mem_re     = mem_re_q;
    assign w_addr     = w_addr_q;
    assign i_addr     = i_addr_q;
    assign data_w_new = data_w_q;
    assign data_i_new = data_i_q;
    assign sel_rdy    = sel_rdy_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign beat_cnt   = beat_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_df_seq.sv
// Scoreboard bench for df_seq: driver queues expected addresses/pairs, a negedge monitor pops and compares.
module tb_df_seq;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 10;
  localparam int MEMD = 1 << AW;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] w_base;
  logic [AW-1:0] i_base;
  logic [LW-1:0] len;
  logic          hold;
  logic          mem_re;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] w_rdata;
  logic [DW-1:0] i_rdata;
  logic [DW-1:0] data_w_new;
  logic [DW-1:0] data_i_new;
  logic          sel_rdy;
  logic          busy;
  logic          done;
  logic [LW-1:0] beat_cnt;
  logic [1:0]    dbg_state;

  df_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .i_base(i_base),
    .len(len), .hold(hold), .mem_re(mem_re), .w_addr(w_addr), .i_addr(i_addr),
    .w_rdata(w_rdata), .i_rdata(i_rdata), .data_w_new(data_w_new),
    .data_i_new(data_i_new), .sel_rdy(sel_rdy), .busy(busy), .done(done),
    .beat_cnt(beat_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memories ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] wmem [MEMD];
  logic [DW-1:0] imem [MEMD];

  initial begin
    w_rdata = '0;
    i_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_re) begin
      w_rdata <= wmem[w_addr];
      i_rdata <= imem[i_addr];
    end
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [2*DW-1:0] exp_q[$];
  int              exp_cyc_q[$];
  int              exp_beat_q[$];
  logic [2*AW-1:0] addr_q[$];
  int exp_done_cyc;
  int exp_beats;
  int exp_len;
  int arm_cnt = 0;
  int abort_cnt = 0;
  int done_cnt = 0;
  int sel_total = 0;
  int last_sel_cyc = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [2*AW-1:0] a;
    logic [2*DW-1:0] e;
    int c;
    int b;
    if (reset) begin
      if (mem_re) begin
        if (addr_q.size() == 0) chk("unexpected_mem_re", 64'd1, 64'd0);
        else begin
          a = addr_q.pop_front();
          chk("w_addr", 64'(w_addr), 64'(a[2*AW-1:AW]));
          chk("i_addr", 64'(i_addr), 64'(a[AW-1:0]));
        end
      end
      if (sel_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_sel_rdy", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          b = exp_beat_q.pop_front();
          chk("pair_data", {data_w_new, data_i_new}, e);
          chk("beat_cnt_run", 64'(beat_cnt), 64'(b));
          if (c >= 0) chk("sel_cycle", 64'(cyc), 64'(c));
        end
        sel_total <= sel_total + 1;
        last_sel_cyc <= cyc;
      end else begin
        chk("data_zero_no_strobe", {data_w_new, data_i_new}, 64'd0);
      end
      if (done) begin
        if (arm_cnt <= done_cnt + abort_cnt) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          if (exp_done_cyc >= 0) chk("done_cycle", 64'(cyc), 64'(exp_done_cyc));
          else if (exp_len > 0 && exp_beats == exp_len)
            chk("done_after_last_sel", 64'(cyc), 64'(last_sel_cyc + 1));
          chk("beat_cnt_done", 64'(beat_cnt), 64'(exp_beats));
          chk("busy_at_done", 64'(busy), 64'd0);
          chk("queues_drained", 64'(exp_q.size() + addr_q.size()), 64'd0);
        end
        done_cnt <= done_cnt + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_ident();
    for (int k = 0; k < MEMD; k++) begin
      wmem[k] = DW'(k);
      imem[k] = DW'(k);
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < MEMD; k++) begin
      wmem[k] = $urandom;
      imem[k] = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
    end
  endtask

  task automatic idle(input int n, input logic check_quiet);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      hold = 1'b0;
      @(negedge clk); #2;
      if (check_quiet) begin
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_state", 64'(dbg_state), 64'd0);
      end
    end
  endtask

  // mode 0: no hold, exact timing; 1: random hold + ignored starts; 2: hold in cycles 2-3;
  // 3: no hold, asynchronous reset after the second strobe.
  task automatic run_seq(input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                         input logic [LW-1:0] ln, input int mode);
    int t0, rel, nb, d0, s0, budget;
    logic [AW-1:0] wa, ia;
    logic finished;
    @(posedge clk); #1;
    t0 = cyc;
    nb = 0;
    for (int k = 0; k < int'(ln); k++) begin
      wa = wb + AW'(k);
      ia = ib + AW'(k);
      addr_q.push_back({wa, ia});
`ifdef DF_SEQ_ZERO_SKIP_EN
      if (imem[ia] != '0) begin
`else
      begin
`endif
        nb++;
        exp_q.push_back({wmem[wa], imem[ia]});
        exp_beat_q.push_back(nb);
        if (mode == 0 || mode == 3 || (mode == 2 && k == 0)) exp_cyc_q.push_back(t0 + 3 + k);
        else exp_cyc_q.push_back(-1);
      end
    end
    exp_beats = nb;
    exp_len = int'(ln);
    exp_done_cyc = (mode == 0) ? ((ln == 0) ? t0 + 2 : t0 + int'(ln) + 3) : -1;
    d0 = done_cnt;
    s0 = sel_total;
    arm_cnt++;
    start = 1'b1;
    w_base = wb;
    i_base = ib;
    len = ln;
    hold = (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
    finished = 1'b0;
    budget = 4 * int'(ln) + 20;
    for (int step = 0; step < budget && !finished; step++) begin
      @(negedge clk); #2;
      rel = cyc - t0;
      if ((mode == 0 || mode == 3) && rel == 1) chk("busy_cycle1", 64'(busy), 64'd1);
      if (done_cnt != d0) finished = 1'b1;
      else if (mode == 3 && sel_total - s0 >= 2) begin
        reset = 1'b0;
        #1;
        chk("outputs_zero_on_reset",
            {mem_re, w_addr, i_addr, sel_rdy, busy, done, beat_cnt, dbg_state}, 64'd0);
        chk("data_zero_on_reset", {data_w_new, data_i_new}, 64'd0);
        addr_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
        exp_beat_q.delete();
        abort_cnt++;
        finished = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
      end else begin
        @(posedge clk); #1;
        rel = cyc - t0;
        start = 1'b0;
        w_base = AW'($urandom);
        i_base = AW'($urandom);
        len = LW'($urandom_range(1, 20));
        case (mode)
          1: begin
            hold = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 3) == 0);
          end
          2: hold = (rel == 2 || rel == 3);
          default: begin
            hold = 1'b0;
            // A start in the DONE cycle must be ignored.
            start = (ln == 0) ? (rel == 2) : (rel == int'(ln) + 3);
          end
        endcase
      end
    end
    if (!finished) chk("sequence_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    start = 1'b0;
    hold = 1'b0;
    w_base = '0;
    i_base = '0;
    len = '0;
    fill_ident();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {mem_re, w_addr, i_addr, sel_rdy, busy, done, beat_cnt, dbg_state}, 64'd0);
    chk("reset_data", {data_w_new, data_i_new}, 64'd0);
    reset = 1'b1;
    idle(8, 1'b1);

    run_seq(10'h010, 10'h200, 10'd4, 0);
    chk("beat_cnt_hold_after_done", 64'(beat_cnt), 64'd4);
    run_seq(10'h040, 10'h050, 10'd3, 2);
    run_seq(10'h000, 10'h000, 10'd0, 0);
    run_seq(10'h3FE, 10'h100, 10'd4, 0);
    run_seq(10'h3FD, 10'h3FF, 10'd1, 0);
    imem[10'h120] = 32'd5;
    imem[10'h121] = 32'd0;
    imem[10'h122] = 32'd7;
    imem[10'h123] = 32'd0;
    run_seq(10'h000, 10'h120, 10'd4, 0);
    idle(2, 1'b1);

    fill_rand();
    run_seq(10'h080, 10'h090, 10'd8, 3);
    idle(3, 1'b1);
    run_seq(10'h080, 10'h090, 10'd8, 0);
    run_seq(AW'($urandom), AW'($urandom), 10'd40, 1);

    for (int n = 0; n < 24; n++) begin
      run_seq(AW'($urandom), AW'($urandom), LW'($urandom_range(0, 12)), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)), 1'b0);
    end
    idle(6, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (tests %0d)", tests);
    $fatal(1, "watchdog");
  end

endmodule
